// File: rtl/painterengine_gpu_reader_arbiter_pkg.sv
// Shared definitions for the GPU reader arbiter: FSM state encodings,
// one-hot grant constants and the default parameter values.
package painterengine_gpu_reader_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_S0 = 2'd1,
        ST_GRANT_S1 = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    // Grant vector is {s1, s0}
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_S0_MAX_BURSTS = 4;
    localparam int DEF_TURNAROUND    = 1;

endpackage

// File: rtl/painterengine_gpu_reader_arbiter.sv
// Shares one AXI burst-reader port between s0 (display, priority) and s1
// (secondary client) with anti-starvation and an enable-low turnaround.
// Ports:
//   i_wire_axi_clock / i_wire_resetn      clock, async active-low reset
//   i_wire_sN_address/length/enable       requester burst request (N=0,1)
//   i_wire_sN_data_next                   requester word-consume strobe
//   o_wire_sN_done/data                   reader status routed to owner
//   o_wire_reader_address/length/enable   registered request to reader
//   o_wire_reader_data_next               owner strobe routed to reader
//   i_wire_reader_done/data               reader status
//   o_wire_grant                          one-hot owner {s1,s0}
module painterengine_gpu_reader_arbiter
    import painterengine_gpu_reader_arbiter_pkg::*;
#(
    parameter int PARAM_ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int PARAM_DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int PARAM_S0_MAX_BURSTS = DEF_S0_MAX_BURSTS,
    parameter int PARAM_TURNAROUND    = DEF_TURNAROUND
) (
    input  logic                           i_wire_axi_clock,
    input  logic                           i_wire_resetn,

    input  logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_s0_address,
    input  logic [8:0]                     i_wire_s0_length,
    input  logic                           i_wire_s0_enable,
    output logic                           o_wire_s0_done,
    output logic [PARAM_DATA_WIDTH-1:0]    o_wire_s0_data,
    input  logic                           i_wire_s0_data_next,

    input  logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_s1_address,
    input  logic [8:0]                     i_wire_s1_length,
    input  logic                           i_wire_s1_enable,
    output logic                           o_wire_s1_done,
    output logic [PARAM_DATA_WIDTH-1:0]    o_wire_s1_data,
    input  logic                           i_wire_s1_data_next,

    output logic [PARAM_ADDRESS_WIDTH-1:0] o_wire_reader_address,
    output logic [8:0]                     o_wire_reader_length,
    output logic                           o_wire_reader_enable,
    input  logic                           i_wire_reader_done,
    input  logic [PARAM_DATA_WIDTH-1:0]    i_wire_reader_data,
    output logic                           o_wire_reader_data_next,

    output logic [1:0]                     o_wire_grant
);

    arb_state_e                     r_state;
    logic [PARAM_ADDRESS_WIDTH-1:0] r_reader_address;
    logic [8:0]                     r_reader_length;
    logic                           r_reader_enable;
    logic [1:0]                     r_grant;
    logic [3:0]                     r_starve_cnt;
    logic [2:0]                     r_turn_cnt;

    logic                           w_starve_full;
    logic                           w_pick_s1;
    logic                           w_data_next;

    assign w_starve_full = (r_starve_cnt == 4'(PARAM_S0_MAX_BURSTS));
    assign w_pick_s1     = i_wire_s1_enable
                         && (!i_wire_s0_enable || w_starve_full);

    always_ff @(posedge i_wire_axi_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state          <= ST_IDLE;
            r_reader_address <= '0;
            r_reader_length  <= '0;
            r_reader_enable  <= 1'b0;
            r_grant          <= GRANT_NONE;
            r_starve_cnt     <= '0;
            r_turn_cnt       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!i_wire_s1_enable)
                        r_starve_cnt <= '0;
                    if (w_pick_s1) begin
                        r_reader_address <= i_wire_s1_address;
                        r_reader_length  <= i_wire_s1_length;
                        r_reader_enable  <= 1'b1;
                        r_grant          <= GRANT_S1;
                        r_starve_cnt     <= '0;
                        r_state          <= ST_GRANT_S1;
                    end else if (i_wire_s0_enable) begin
                        r_reader_address <= i_wire_s0_address;
                        r_reader_length  <= i_wire_s0_length;
                        r_reader_enable  <= 1'b1;
                        r_grant          <= GRANT_S0;
                        r_state          <= ST_GRANT_S0;
                        // count only grants that make a waiting s1 wait longer
                        if (i_wire_s1_enable && !w_starve_full)
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                ST_GRANT_S0: begin
                    if (!i_wire_s0_enable) begin
                        r_reader_enable <= 1'b0;
                        r_grant         <= GRANT_NONE;
                        r_turn_cnt      <= '0;
                        r_state         <= ST_RELEASE;
                    end
                end
                ST_GRANT_S1: begin
                    if (!i_wire_s1_enable) begin
                        r_reader_enable <= 1'b0;
                        r_grant         <= GRANT_NONE;
                        r_turn_cnt      <= '0;
                        r_state         <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (r_turn_cnt == 3'(PARAM_TURNAROUND - 1))
                        r_state <= ST_IDLE;
                    else
                        r_turn_cnt <= r_turn_cnt + 3'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_next = 1'b0;
        unique case (1'b1)
            r_grant[0]: w_data_next = i_wire_s0_data_next;
            r_grant[1]: w_data_next = i_wire_s1_data_next;
            default:    w_data_next = 1'b0;
        endcase
    end

    // done is also gated by the owner's enable so a done arriving in the
    // cycle the owner releases is never seen by it
    assign o_wire_s0_done = r_grant[0] & i_wire_s0_enable & i_wire_reader_done;
    assign o_wire_s1_done = r_grant[1] & i_wire_s1_enable & i_wire_reader_done;
    assign o_wire_s0_data = r_grant[0] ? i_wire_reader_data : '0;
    assign o_wire_s1_data = r_grant[1] ? i_wire_reader_data : '0;

    assign o_wire_reader_address   = r_reader_address;
    assign o_wire_reader_length    = r_reader_length;
    assign o_wire_reader_enable    = r_reader_enable;
    assign o_wire_reader_data_next = w_data_next;
    assign o_wire_grant            = r_grant;

endmodule
